// File: rtl/ponylink_traffic_gen.sv
// PonyLink stream traffic generator (up/down counter) and sequence checker with hysteresis mode.
// Define TRAFFIC_PKTCHK_EN to also check rx_tlast placement against RX_PKT_LEN.
`timescale 1ns/1ps
module ponylink_traffic_gen #(
    parameter int TDATA_WIDTH  = 16,
    parameter int TX_UP_STEP   = 2,
    parameter int TX_DOWN_STEP = 5,
    parameter int RX_UP_STEP   = 3,
    parameter int RX_DOWN_STEP = 7,
    parameter logic [TDATA_WIDTH-1:0] LO_THRESH = 'h4000,
    parameter logic [TDATA_WIDTH-1:0] HI_THRESH = 'hc000,
    parameter int TX_PKT_LEN   = 0,
    parameter int RX_PKT_LEN   = 0,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    send_mode,
    output logic [TDATA_WIDTH-1:0]  tx_tdata,
    output logic                    tx_tvalid,
    output logic                    tx_tlast,
    input  logic                    tx_tready,
    input  logic [TDATA_WIDTH-1:0]  rx_tdata,
    input  logic                    rx_tvalid,
    input  logic                    rx_tlast,
    output logic                    rx_tready,
    input  logic                    clear_errors,
    output logic                    recv_mode,
    output logic                    check_locked,
    output logic                    err_flag,
    output logic [ERRCNT_WIDTH-1:0] err_count
);
    localparam int W = TDATA_WIDTH;
    localparam logic [W-1:0] TX_UP   = W'(TX_UP_STEP);
    localparam logic [W-1:0] TX_DOWN = W'(TX_DOWN_STEP);
    localparam logic [W-1:0] RX_UP   = W'(RX_UP_STEP);
    localparam logic [W-1:0] RX_DOWN = W'(RX_DOWN_STEP);
    localparam int TXCW = (TX_PKT_LEN > 1) ? $clog2(TX_PKT_LEN) : 1;
    localparam logic [TXCW-1:0] TX_LAST = TXCW'(TX_PKT_LEN - 1);
    localparam logic [ERRCNT_WIDTH-1:0] ERR_MAX = '1;
    localparam logic [ERRCNT_WIDTH-1:0] ERR_ONE = ERRCNT_WIDTH'(1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    logic [W-1:0]    txData_q, txData_d;
    logic            txValid_q, txValid_d;
    logic [TXCW-1:0] txCnt_q, txCnt_d;
    logic            rxReady_q;
    logic            recvMode_q, recvMode_d;
    state_t          state_q, state_d;
    logic [W-1:0]    prev_q, prev_d;
    logic            errFlag_q;
    logic [ERRCNT_WIDTH-1:0] errCount_q, errCount_d;
    logic            txHs, rxHs, dataErr, lastErr, anyErr;

    assign txHs = txValid_q & tx_tready;
    assign rxHs = rx_tvalid & rxReady_q;

    // Valid may only be withdrawn after the current word has been taken.
    always_comb begin
        txValid_d = txValid_q;
        txData_d  = txData_q;
        txCnt_d   = txCnt_q;
        if (!txValid_q) begin
            txValid_d = enable;
        end else if (txHs && !enable) begin
            txValid_d = 1'b0;
        end
        if (txHs) begin
            txData_d = send_mode ? (txData_q - TX_DOWN) : (txData_q + TX_UP);
            if (TX_PKT_LEN != 0) begin
                txCnt_d = (txCnt_q == TX_LAST) ? '0 : (txCnt_q + TXCW'(1));
            end
        end
    end

    always_comb begin
        recvMode_d = recvMode_q;
        state_d    = state_q;
        prev_d     = prev_q;
        dataErr    = 1'b0;
        if (rxHs) begin
            if (rx_tdata < LO_THRESH) begin
                recvMode_d = 1'b0;
            end else if (rx_tdata >= HI_THRESH) begin
                recvMode_d = 1'b1;
            end
            prev_d = rx_tdata;
            if (state_q == UNLOCKED) begin
                state_d = LOCKED;
            end else if ((rx_tdata != prev_q + RX_UP) && (rx_tdata != prev_q - RX_DOWN)) begin
                dataErr = 1'b1;
            end
        end
    end

`ifdef TRAFFIC_PKTCHK_EN
    localparam int RXCW = (RX_PKT_LEN > 1) ? $clog2(RX_PKT_LEN) : 1;
    localparam logic [RXCW-1:0] RX_LAST = RXCW'(RX_PKT_LEN - 1);
    logic [RXCW-1:0] rxCnt_q, rxCnt_d;

    // A misplaced tlast restarts packet framing from the next word.
    always_comb begin
        rxCnt_d = rxCnt_q;
        lastErr = 1'b0;
        if ((RX_PKT_LEN != 0) && rxHs) begin
            if (rx_tlast != (rxCnt_q == RX_LAST)) begin
                lastErr = 1'b1;
                rxCnt_d = '0;
            end else if (rxCnt_q == RX_LAST) begin
                rxCnt_d = '0;
            end else begin
                rxCnt_d = rxCnt_q + RXCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxCnt_q <= '0;
        end else begin
            rxCnt_q <= rxCnt_d;
        end
    end
`else
    logic unusedPktChk;
    assign unusedPktChk = rx_tlast ^ (RX_PKT_LEN != 0);
    assign lastErr = 1'b0;
`endif

    assign anyErr = dataErr | lastErr;

    always_comb begin
        errCount_d = errCount_q;
        if (clear_errors) begin
            errCount_d = anyErr ? ERR_ONE : '0;
        end else if (anyErr && (errCount_q != ERR_MAX)) begin
            errCount_d = errCount_q + ERR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txData_q   <= '0;
            txValid_q  <= 1'b0;
            txCnt_q    <= '0;
            rxReady_q  <= 1'b0;
            recvMode_q <= 1'b0;
            state_q    <= UNLOCKED;
            prev_q     <= '0;
            errFlag_q  <= 1'b0;
            errCount_q <= '0;
        end else begin
            txData_q   <= txData_d;
            txValid_q  <= txValid_d;
            txCnt_q    <= txCnt_d;
            rxReady_q  <= 1'b1;
            recvMode_q <= recvMode_d;
            state_q    <= state_d;
            prev_q     <= prev_d;
            errFlag_q  <= anyErr;
            errCount_q <= errCount_d;
        end
    end

    assign tx_tdata     = txData_q;
    assign tx_tvalid    = txValid_q;
    assign tx_tlast     = (TX_PKT_LEN != 0) && txValid_q && (txCnt_q == TX_LAST);
    assign rx_tready    = rxReady_q;
    assign recv_mode    = recvMode_q;
    assign check_locked = (state_q == LOCKED);
    assign err_flag     = errFlag_q;
    assign err_count    = errCount_q;
endmodule

// File: doc/ponylink_traffic_gen.md
Name: ponylink_traffic_gen

Overview:
Parametrised AXI-stream traffic generator and checker for one end of a PonyLink.
- Generator side drives the core's in_* stream with an up/down counting pattern.
- Checker side consumes the core's out_* stream. It derives a hysteresis mode bit from the data and counts sequence errors.
- One instance sits beside each ponylink_master/ponylink_slave in demo and test tops. It replaces hand-written sender/receiver logic.

Parameters:
- TDATA_WIDTH, 16: stream data width (W).
- TX_UP_STEP, 2: generator increment when send_mode=0.
- TX_DOWN_STEP, 5: generator decrement when send_mode=1.
- RX_UP_STEP, 3: expected increment of the remote generator.
- RX_DOWN_STEP, 7: expected decrement of the remote generator.
- LO_THRESH, 'h4000: rx data below this clears recv_mode (W bits).
- HI_THRESH, 'hc000: rx data at or above this sets recv_mode (W bits).
- TX_PKT_LEN, 0: words per tx packet; 0 means tx_tlast is never asserted.
- RX_PKT_LEN, 0: expected words per rx packet; used only with TRAFFIC_PKTCHK_EN.
- ERRCNT_WIDTH, 8: width of the error counter.

Ports:
- clk, input, 1: single clock for all logic.
- reset, input, 1: asynchronous reset, active-high.
- enable, input, 1: generator run request.
- send_mode, input, 1: generator direction; 0 = up, 1 = down.
- tx_tdata, output, W: generator data.
- tx_tvalid, output, 1: generator valid.
- tx_tlast, output, 1: generator end-of-packet.
- tx_tready, input, 1: sink ready.
- rx_tdata, input, W: received data.
- rx_tvalid, input, 1: received valid.
- rx_tlast, input, 1: received end-of-packet.
- rx_tready, output, 1: always 1 when not in reset.
- clear_errors, input, 1: synchronous clear of err_count.
- recv_mode, output, 1: hysteresis mode derived from rx data.
- check_locked, output, 1: checker has a reference word.
- err_flag, output, 1: one-cycle pulse per detected error.
- err_count, output, ERRCNT_WIDTH: saturating error count.

Behaviour:
- Reset: every register is cleared asynchronously to 0 (tx_tdata, tx_tvalid, tx_tlast, tx packet counter, recv_mode, check_locked, err_flag, err_count, prev word, rx packet counter).
  - rx_tready is 0 during reset and 1 from the first cycle after release.
  - Reset asserted mid-transfer drops tx_tvalid immediately; no handshake is counted.
- Generator handshake: tx_hs = tx_tvalid & tx_tready.
- tx_tvalid transitions:
  - Rises the cycle after enable=1 is sampled.
  - Once high, it falls only on a cycle with tx_hs while enable=0; AXI hold rule.
  - tx_tdata and tx_tlast are stable while tx_tvalid=1 and tx_tready=0.
- Data update on tx_hs: tx_tdata <= tx_tdata + TX_UP_STEP if send_mode=0, else tx_tdata - TX_DOWN_STEP.
  - Arithmetic is modulo 2^W: 0 - 5 = 'hfffb; 'hffff + 2 = 'h0001.
  - send_mode is sampled only at tx_hs.
- tx packet counter (TX_PKT_LEN>0):
  - Counts tx_hs events.
  - tx_tlast=1 on the TX_PKT_LEN-th word of each packet.
  - Counter returns to 0 on the handshake of that word.
- Receiver:
  - Accepted word: rx_hs = rx_tvalid & rx_tready.
  - On rx_hs, recv_mode <= 0 if rx_tdata < LO_THRESH; recv_mode <= 1 if rx_tdata >= HI_THRESH; otherwise unchanged. Comparisons are unsigned.
- Checker FSM:
  - UNLOCKED: the first rx_hs loads prev <= rx_tdata, then the FSM goes to LOCKED; check_locked=1 from the next cycle.
  - LOCKED: rx_hs is a match if rx_tdata == prev + RX_UP_STEP or rx_tdata == prev - RX_DOWN_STEP (mod 2^W).
  - Match: prev <= rx_tdata.
  - Mismatch: err_flag=1 next cycle, err_count increments, prev <= rx_tdata (resync); FSM stays LOCKED.
- err_count:
  - Saturates at all-ones.
  - clear_errors alone sets it to 0.
  - clear_errors together with a new error gives 1.
- Latency: recv_mode, err_flag and err_count update 1 cycle after rx_hs.

Optional Feature:
- Macro: TRAFFIC_PKTCHK_EN.
- Defined, with RX_PKT_LEN>0:
  - An rx word counter checks that rx_tlast=1 exactly on every RX_PKT_LEN-th accepted word.
  - Missing or early tlast is an error (same flag/count path as a data mismatch) and resets the counter to 0.
  - A data error and a tlast error on the same word count once.
- Not defined: rx_tlast is ignored, RX_PKT_LEN is unused, and no counter logic exists.

Test Plan:
- Reset release, enable=1, tx_tready=1, send_mode=0 -> tx_tdata sequence 0,2,4,6; tx_tvalid rises 1 cycle after enable.
- tx_tdata=0, send_mode=1, one handshake -> tx_tdata='hfffb. tx_tready held 0 for 5 cycles -> tx_tdata stable, tx_tvalid stays 1 even if enable drops.
- TX_PKT_LEN=4, continuous handshakes -> tx_tlast high on words 4, 8, 12 only.
- rx words 'h3000, 'h8000, 'hc000, 'h8000, 'h3fff -> recv_mode 0,0,1,1,0.
- rx words 10,13,6,99,102 (RX steps 3/7) -> check_locked after 10; err_flag single pulse at 99; err_count=1. clear_errors on the same cycle as a later error -> err_count=1.
- TRAFFIC_PKTCHK_EN, RX_PKT_LEN=3, valid sequence with tlast on word 2 -> err_count 1; tlast on word 3 thereafter -> no further errors.
